// File: rtl/dmem_arb_defs.sv
// Shared definitions for the dual-port data-memory arbiter.
//   state_t     : sequencer states (idle, one-cycle memory access, response hold)
//   MEMRW_*     : Data_Memory MemRW encodings (0 = write, 1 = read)
//   P_CORE/P_DMA: requester port ids
//   other_port  : round-robin helper, returns the id that is not the given one
package dmem_arb_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic MEMRW_WRITE = 1'b0;
    localparam logic MEMRW_READ  = 1'b1;

    localparam logic P_CORE = 1'b0;
    localparam logic P_DMA  = 1'b1;

    function automatic logic other_port(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector (bit i = port i has a valid request)
//   take       : the current grant was consumed; remember it as last grant
//   gnt_valid  : at least one request present
//   gnt_id     : winning port id (meaningful only when gnt_valid=1)
// The last-grant register resets to P_DMA so that port 0 wins the first tie.
module rr_arb2
    import dmem_arb_defs::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic last_grant_reg;

    always_comb begin
        gnt_valid = |req;
        gnt_id    = P_CORE;
        unique case (req)
            2'b01:   gnt_id = P_CORE;
            2'b10:   gnt_id = P_DMA;
            2'b11:   gnt_id = other_port(last_grant_reg);
            default: gnt_id = P_CORE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= P_DMA;
        end else if (take) begin
            last_grant_reg <= gnt_id;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer in front of Data_Memory
// (word-indexed, combinational read, posedge write when MemRW=0).
//   clk, rst_n          : clock shared with the memory, async active-low reset
//   pN_req_valid/ready  : request handshake (N=0 core LSU, N=1 DMA/debug)
//   pN_req_we/addr/wdata: request fields (we=1 write), addr is a word index
//   pN_rsp_valid/ready  : response handshake
//   pN_rsp_rdata/err    : read data (0 for writes/errors), out-of-range flag
//   mem_addr/wdata/memrw: memory port, memrw 0=write 1=read
//   mem_rdata           : memory read data
// Sequence: IDLE (accept) -> ACCESS (one memory cycle) -> RESP (hold until
// consumed). mem_memrw is purely a decode of the state register, so it only
// drops to write during ACCESS of an in-range write, and it returns to read
// the instant rst_n falls.
module dmem_arbiter
    import dmem_arb_defs::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int IDX_BITS = 3
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_rsp_valid,
    input  logic              p0_rsp_ready,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    output logic              p0_rsp_err,

    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_rsp_valid,
    input  logic              p1_rsp_ready,
    output logic [DATA_W-1:0] p1_rsp_rdata,
    output logic              p1_rsp_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_memrw,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t              state_reg, state_next;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic                id_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic                err_reg;

    logic                gnt_valid;
    logic                gnt_id;
    logic                handshake;
    logic                out_of_range;
    logic                rsp_taken;

    logic [1:0]          req_valid_vec;
    logic [1:0]          req_ready_vec;
    logic [1:0]          rsp_valid_vec;
    logic [1:0]          rsp_err_vec;
    logic [DATA_W-1:0]   rsp_rdata_arr [2];

    assign req_valid_vec = {p1_req_valid, p0_req_valid};

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid_vec),
        .take      (handshake),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Any address bit above the decoded index range makes the access
    // illegal; the memory would otherwise silently alias it.
    assign out_of_range = |addr_reg[ADDR_W-1:IDX_BITS];

    assign handshake = (state_reg == ST_IDLE) && gnt_valid;
    assign rsp_taken = (id_reg == P_DMA) ? p1_rsp_ready : p0_rsp_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam logic PID = 1'(gi);
            assign req_ready_vec[gi] = handshake && (gnt_id == PID);
            assign rsp_valid_vec[gi] = (state_reg == ST_RESP) && (id_reg == PID);
            assign rsp_err_vec[gi]   = rsp_valid_vec[gi] && err_reg;
            assign rsp_rdata_arr[gi] = rsp_valid_vec[gi] ? rdata_reg : '0;
        end
    endgenerate

    assign p0_req_ready = req_ready_vec[0];
    assign p1_req_ready = req_ready_vec[1];
    assign p0_rsp_valid = rsp_valid_vec[0];
    assign p1_rsp_valid = rsp_valid_vec[1];
    assign p0_rsp_err   = rsp_err_vec[0];
    assign p1_rsp_err   = rsp_err_vec[1];
    assign p0_rsp_rdata = rsp_rdata_arr[0];
    assign p1_rsp_rdata = rsp_rdata_arr[1];

    // Next state and memory port decode.
    always_comb begin
        state_next = state_reg;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_memrw  = MEMRW_READ;
        unique case (state_reg)
            ST_IDLE: begin
                if (handshake) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_addr   = addr_reg;
                mem_wdata  = we_reg ? wdata_reg : '0;
                mem_memrw  = (we_reg && !out_of_range) ? MEMRW_WRITE : MEMRW_READ;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_taken) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Request latch: captured on the accepting edge, stable through
    // ACCESS and RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            id_reg    <= P_CORE;
        end else if (handshake) begin
            id_reg    <= gnt_id;
            we_reg    <= (gnt_id == P_DMA) ? p1_req_we    : p0_req_we;
            addr_reg  <= (gnt_id == P_DMA) ? p1_req_addr  : p0_req_addr;
            wdata_reg <= (gnt_id == P_DMA) ? p1_req_wdata : p0_req_wdata;
        end
    end

    // Response register: loaded at the end of the access cycle, the same
    // edge on which a write commits in the memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else if (state_reg == ST_ACCESS) begin
            rdata_reg <= (!we_reg && !out_of_range) ? mem_rdata : '0;
            err_reg   <= out_of_range;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural
// Data_Memory model (8 words, combinational read, posedge write on MemRW=0).
// Outputs are sampled 1-2 time units after the rising edge.
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [1:0]    req_we;
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_wdata [2];
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready;
    logic [DW-1:0] rsp_rdata [2];
    logic [1:0]    rsp_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_memrw;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem [8];
    logic          init_mem;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 8; i++) mem[i] <= 32'hA000_0000 | i;
        end else if (mem_memrw == 1'b0) begin
            mem[mem_addr[2:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[2:0]];

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .IDX_BITS(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .p0_req_valid (req_valid[0]),
        .p0_req_ready (req_ready[0]),
        .p0_req_we    (req_we[0]),
        .p0_req_addr  (req_addr[0]),
        .p0_req_wdata (req_wdata[0]),
        .p0_rsp_valid (rsp_valid[0]),
        .p0_rsp_ready (rsp_ready[0]),
        .p0_rsp_rdata (rsp_rdata[0]),
        .p0_rsp_err   (rsp_err[0]),
        .p1_req_valid (req_valid[1]),
        .p1_req_ready (req_ready[1]),
        .p1_req_we    (req_we[1]),
        .p1_req_addr  (req_addr[1]),
        .p1_req_wdata (req_wdata[1]),
        .p1_rsp_valid (rsp_valid[1]),
        .p1_rsp_ready (rsp_ready[1]),
        .p1_rsp_rdata (rsp_rdata[1]),
        .p1_rsp_err   (rsp_err[1]),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_memrw    (mem_memrw),
        .mem_rdata    (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[p] = v;
        req_we[p]    = we;
        req_addr[p]  = a;
        req_wdata[p] = d;
    endtask

    // One complete transaction on a single port, response consumed at once.
    task automatic do_req(input int p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_rdata,
                          input logic exp_err, input logic exp_memrw);
        set_req(p, 1'b1, we, a, d);
        #1;
        chk($sformatf("p%0d_req_ready_idle", p), req_ready[p], 1'b1);
        chk("memrw_in_idle", mem_memrw, 1'b1);
        tick();
        set_req(p, 1'b0, 1'b0, '0, '0);
        #1;
        chk($sformatf("p%0d_access_memrw", p), mem_memrw, exp_memrw);
        chk($sformatf("p%0d_access_addr", p), mem_addr, a);
        chk($sformatf("p%0d_ready_in_access", p), req_ready[p], 1'b0);
        tick();
        chk($sformatf("p%0d_rsp_valid", p), rsp_valid[p], 1'b1);
        chk($sformatf("p%0d_rsp_rdata", p), rsp_rdata[p], exp_rdata);
        chk($sformatf("p%0d_rsp_err", p), rsp_err[p], exp_err);
        chk("memrw_in_resp", mem_memrw, 1'b1);
        rsp_ready[p] = 1'b1;
        tick();
        rsp_ready[p] = 1'b0;
        chk($sformatf("p%0d_rsp_valid_after", p), rsp_valid[p], 1'b0);
        $display("txn port=%0d we=%0b addr=%0h wdata=%0h exp_rdata=%0h exp_err=%0b",
                 p, we, a, d, exp_rdata, exp_err);
    endtask

    initial begin
        rst_n     = 1'b0;
        init_mem  = 1'b1;
        req_valid = '0;
        req_we    = '0;
        rsp_ready = '0;
        for (int i = 0; i < 2; i++) begin
            req_addr[i]  = '0;
            req_wdata[i] = '0;
        end

        // Reset values
        #2;
        chk("rst_memrw", mem_memrw, 1'b1);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_err", rsp_err, 2'b00);
        chk("rst_rsp_rdata0", rsp_rdata[0], 32'h0);
        tick();
        tick();
        init_mem = 1'b0;
        rst_n    = 1'b1;

        // Idle for 10 cycles
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_memrw", mem_memrw, 1'b1);
            chk("idle_req_ready", req_ready, 2'b00);
            chk("idle_rsp_valid", rsp_valid, 2'b00);
        end
        $display("txn idle 10 cycles");

        // Write then read back addr 3
        do_req(0, 1'b1, 32'd3, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
        chk("mem3_after_write", mem[3], 32'hDEAD_BEEF);
        do_req(0, 1'b0, 32'd3, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);

        // Fresh reset so the first tie goes to p0, then contention
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rsp_ready = 2'b11;
        set_req(0, 1'b1, 1'b0, 32'd1, '0);
        set_req(1, 1'b1, 1'b0, 32'd2, '0);
        for (int k = 0; k < 4; k++) begin
            int g;
            g = k % 2;
            #1;
            chk($sformatf("rr%0d_ready", k), req_ready, (g == 0) ? 2'b01 : 2'b10);
            tick();
            tick();
            chk($sformatf("rr%0d_rsp_valid", k), rsp_valid, (g == 0) ? 2'b01 : 2'b10);
            chk($sformatf("rr%0d_rdata", k), rsp_rdata[g], (g == 0) ? 32'hA000_0001 : 32'hA000_0002);
            $display("txn rr k=%0d grant=%0d rdata=%0h", k, g, rsp_rdata[g]);
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tick();

        // Out-of-range write from p1, then addr 0 still intact
        do_req(1, 1'b1, 32'h10, 32'h1234_5678, 32'h0, 1'b1, 1'b1);
        chk("mem0_untouched", mem[0], 32'hA000_0000);
        do_req(0, 1'b0, 32'h0, 32'h0, 32'hA000_0000, 1'b0, 1'b1);

        // Response back-pressure on p0 with p1 waiting
        set_req(0, 1'b1, 1'b0, 32'd3, '0);
        #1;
        chk("bp_p0_ready", req_ready[0], 1'b1);
        tick();
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b1, 1'b0, 32'd4, '0);
        #1;
        chk("bp_p1_blocked_access", req_ready[1], 1'b0);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", rsp_valid[0], 1'b1);
            chk("bp_rsp_rdata", rsp_rdata[0], 32'hDEAD_BEEF);
            chk("bp_p1_blocked", req_ready[1], 1'b0);
            tick();
        end
        rsp_ready[0] = 1'b1;
        #1;
        chk("bp_p1_blocked_on_ready", req_ready[1], 1'b0);
        tick();
        rsp_ready[0] = 1'b0;
        #1;
        chk("bp_p0_rsp_done", rsp_valid[0], 1'b0);
        chk("bp_p1_ready_now", req_ready[1], 1'b1);
        tick();
        set_req(1, 1'b0, 1'b0, '0, '0);
        tick();
        chk("bp_p1_rdata", rsp_rdata[1], 32'hA000_0004);
        rsp_ready[1] = 1'b1;
        tick();
        rsp_ready[1] = 1'b0;
        $display("txn backpressure p0 rdata=deadbeef, p1 addr 4 served after");

        // Reset asserted during ACCESS of a write to addr 5
        set_req(0, 1'b1, 1'b1, 32'd5, 32'h5555_5555);
        tick();
        set_req(0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("mid_rst_access_memrw", mem_memrw, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_memrw", mem_memrw, 1'b1);
        chk("mid_rst_mem_addr", mem_addr, 32'h0);
        chk("mid_rst_mem_wdata", mem_wdata, 32'h0);
        chk("mid_rst_rsp_valid", rsp_valid, 2'b00);
        tick();
        chk("mid_rst_mem5", mem[5], 32'hA000_0005);
        rst_n = 1'b1;
        tick();
        $display("txn reset during write access addr 5");
        do_req(0, 1'b0, 32'd5, 32'h0, 32'hA000_0005, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and access sequencer in front of Data_Memory (word-indexed, combinational read, posedge write when MemRW=0).
- Port 0 is the core load/store unit; port 1 is the DMA/debug loader.
- Arbitrates round-robin, drives the single memory port for exactly one access cycle, and returns a registered response over a valid/ready handshake.
- Guarantees MemRW stays 1 (read) whenever no write is being issued, so the memory never takes a spurious write.

Parameters:
- DATA_W, 32, data width of the memory and the requesters.
- ADDR_W, 32, requester and memory address width.
- IDX_BITS, 3, number of address bits the memory decodes; valid word indices are 0 .. 2**IDX_BITS-1.

Ports:
- clk  in  1  rising-edge clock, shared with Data_Memory
- rst_n  in  1  asynchronous active-low reset
- p0_req_valid / p1_req_valid  in  1  request present
- p0_req_ready / p1_req_ready  out  1  request accepted this cycle
- p0_req_we / p1_req_we  in  1  1 = write, 0 = read
- p0_req_addr / p1_req_addr  in  ADDR_W  word index
- p0_req_wdata / p1_req_wdata  in  DATA_W  write data
- p0_rsp_valid / p1_rsp_valid  out  1  response present
- p0_rsp_ready / p1_rsp_ready  in  1  response consumed
- p0_rsp_rdata / p1_rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- p0_rsp_err / p1_rsp_err  out  1  address out of range
- mem_addr  out  ADDR_W  to Data_Memory addr
- mem_wdata  out  DATA_W  to Data_Memory DataW
- mem_memrw  out  1  to Data_Memory MemRW (0 = write, 1 = read)
- mem_rdata  in  DATA_W  from Data_Memory DataR

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all req_ready, rsp_valid and rsp_err = 0; rsp_rdata = 0.
  - mem_memrw=1, mem_addr=0, mem_wdata=0.
  - last_grant=1, so port 0 wins the first tie.
- FSM IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational: asserted only toward the port chosen by the arbiter, and only when that port's valid=1.
  - Arbitration:
    - Only one port valid: it wins.
    - Both valid: the port != last_grant wins.
  - On handshake: latch we/addr/wdata and the granted id, update last_grant, go to ACCESS.
  - No valid requests: stay in IDLE, memory outputs at idle values.
- ACCESS (exactly one cycle):
  - Drive mem_addr from the latched address.
  - mem_memrw = ~we, but forced to 1 if the access is out of range.
  - mem_wdata from the latched data when writing, 0 otherwise.
  - Out of range means any latched addr bit at or above IDX_BITS is set; the memory must not alias it.
  - At the clock edge: capture mem_rdata into the response register for an in-range read, 0 otherwise; set err; go to RESP.
  - The write commits on this same edge.
- RESP:
  - rsp_valid=1 on the granted port only; rdata and err held stable.
  - Leave to IDLE on the cycle rsp_ready=1.
  - No request is accepted while in RESP.
- Latency and throughput:
  - Request accepted at edge N; memory accessed in cycle N+1; rsp_valid high from cycle N+2.
  - Best throughput is one access per 3 cycles.
- mem_memrw=0 only ever in ACCESS with an in-range write. This is a hard invariant.
- Reset mid-operation:
  - Asserted in ACCESS before the edge: no write occurs, because mem_memrw returns to 1 asynchronously.
  - Any pending response is dropped.
- Each port has at most one outstanding request; a requester must not change its req_* signals while valid=1 and ready=0.

Decomposition:
- Shared package/include `dmem_arb_defs`:
  - State encodings ST_IDLE, ST_ACCESS, ST_RESP.
  - MEMRW_WRITE=0 and MEMRW_READ=1.
  - Port ids P_CORE=0 and P_DMA=1.
- One sub-module, `rr_arb2`: the 2-way round-robin arbiter (combinational grant plus last_grant register).

Test Plan:
- Reset, then idle for 10 cycles -> mem_memrw=1 every cycle; no req_ready or rsp_valid.
- p0 write addr=3, wdata=0xDEADBEEF, then p0 read addr=3 -> mem_memrw=0 exactly one cycle; read rsp_rdata=0xDEADBEEF at N+2, err=0.
- p0 and p1 both assert valid reads continuously -> grants alternate 0,1,0,1; first grant goes to p0 after reset.
- p1 write addr=0x10 (out of range, IDX_BITS=3) -> mem_memrw stays 1; rsp_err=1; rdata=0; a later read of addr=0 returns its original contents.
- p0 read with rsp_ready held 0 for 5 cycles -> rsp_valid and rdata stable; a p1 request is not accepted until one cycle after p0 rsp_ready=1.
- Assert rst_n=0 during ACCESS of a write to addr=5 -> addr 5 unchanged; outputs at reset values immediately.
